// File: rtl/id_ex_pipe_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_pkg
// Shared definitions for the ID/EX pipeline register.
//   - Packed control word layout (bit offsets of each field in id_ctrl/ex_ctrl)
//     {alu_op[3:0], alub_sel, wd_sel[1:0], mem_we, mem_re, br_type[2:0]}
//   - CTRL_NOP: the all-zero control word loaded into a bubble
//   - upd_e: per-edge update action chosen for the EX register
// -----------------------------------------------------------------------------
package id_ex_pipe_pkg;

   localparam int unsigned CTRL_W       = 12;

   localparam int unsigned CTRL_BRTYPE  = 0;   // [2:0]
   localparam int unsigned CTRL_MEMRE   = 3;
   localparam int unsigned CTRL_MEMWE   = 4;
   localparam int unsigned CTRL_WDSEL   = 5;   // [6:5]
   localparam int unsigned CTRL_ALUBSEL = 7;
   localparam int unsigned CTRL_ALUOP   = 8;   // [11:8]

   localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

   typedef enum logic [1:0] {
      UPD_LOAD  = 2'd0,   // capture the ID instruction
      UPD_HOLD  = 2'd1,   // downstream freeze
      UPD_FLUSH = 2'd2,   // taken branch/jump: kill ID instruction
      UPD_STALL = 2'd3    // load-use: insert bubble, ID re-presents
   } upd_e;

   function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] c);
      return c[CTRL_MEMRE];
   endfunction

endpackage

// File: rtl/id_ex_pipe_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that increments by one and sticks at all-ones.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset, clears the count
//   inc    : count one event this cycle
//   hold   : freeze the count (takes priority over inc)
//   count  : current count value
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             hold,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (!hold && inc && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/id_ex_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_pipe
// ID -> EX pipeline register of the 5-stage RV32I core.
//   Inputs from ID : id_valid, id_pc, id_rs1/2, id_rD1/2, id_imm, id_wr, id_we,
//                    id_ctrl, id_use_rs1/2
//   Pipeline ctrl  : stall_in (freeze), flush (kill ID instruction)
//   Forwarding     : fwd_a_sel/fwd_b_sel with fwd_data_a/fwd_data_b, applied
//                    combinationally to the registered operands in EX
//   Outputs to EX  : ex_valid, ex_pc, ex_imm, ex_rs1/2, ex_wr, ex_we, ex_ctrl,
//                    ex_op_a, ex_op_b
//   Hazard         : stall_req (load-use, to PC and IF/ID)
//   Trace counters : stall_cnt, flush_cnt (saturating)
// Reset is synchronous, active-low.
// -----------------------------------------------------------------------------
module id_ex_pipe
   import id_ex_pipe_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [XLEN-1:0]   id_rD1,
   input  logic [XLEN-1:0]   id_rD2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [4:0]        id_wr,
   input  logic              id_we,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,

   input  logic              stall_in,
   input  logic              flush,

   input  logic              fwd_a_sel,
   input  logic              fwd_b_sel,
   input  logic [XLEN-1:0]   fwd_data_a,
   input  logic [XLEN-1:0]   fwd_data_b,

   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_imm,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_wr,
   output logic              ex_we,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [XLEN-1:0]   ex_op_a,
   output logic [XLEN-1:0]   ex_op_b,

   output logic              stall_req,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic              r_valid;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_imm;
   logic [4:0]        r_rs1;
   logic [4:0]        r_rs2;
   logic [4:0]        r_wr;
   logic              r_we;
   logic [CTRL_W-1:0] r_ctrl;
   logic [XLEN-1:0]   r_rd1;
   logic [XLEN-1:0]   r_rd2;

   logic              w_hazard;
   logic              w_stall_req;
   upd_e              w_upd;

   // Load in EX whose destination (not x0) is read by the ID instruction.
   always_comb begin
      w_hazard = r_valid && ctrl_is_load(r_ctrl) && (r_wr != 5'd0) && id_valid &&
                 ((id_use_rs1 && (id_rs1 == r_wr)) ||
                  (id_use_rs2 && (id_rs2 == r_wr)));
      // A taken branch kills the ID instruction anyway, so no stall is needed.
      w_stall_req = w_hazard && !flush;
   end

   always_comb begin
      w_upd = UPD_LOAD;
      if (stall_in) begin
         w_upd = UPD_HOLD;
      end else if (flush) begin
         w_upd = UPD_FLUSH;
      end else if (w_stall_req) begin
         w_upd = UPD_STALL;
      end
   end

   // Bubbles only clear the qualifying fields; payload registers keep their
   // previous contents since they are ignored while ex_valid is low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_imm   <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_wr    <= '0;
         r_we    <= 1'b0;
         r_ctrl  <= CTRL_NOP;
         r_rd1   <= '0;
         r_rd2   <= '0;
      end else begin
         case (w_upd)
            UPD_HOLD: begin
            end
            UPD_FLUSH, UPD_STALL: begin
               r_valid <= 1'b0;
               r_we    <= 1'b0;
               r_ctrl  <= CTRL_NOP;
            end
            UPD_LOAD: begin
               r_valid <= id_valid;
               r_pc    <= id_pc;
               r_imm   <= id_imm;
               r_rs1   <= id_rs1;
               r_rs2   <= id_rs2;
               r_wr    <= id_wr;
               r_we    <= id_we;
               r_ctrl  <= id_ctrl;
               r_rd1   <= id_rD1;
               r_rd2   <= id_rD2;
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_upd == UPD_STALL),
      .hold  (stall_in),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_upd == UPD_FLUSH),
      .hold  (stall_in),
      .count (flush_cnt)
   );

   always_comb begin
      ex_valid  = r_valid;
      ex_pc     = r_pc;
      ex_imm    = r_imm;
      ex_rs1    = r_rs1;
      ex_rs2    = r_rs2;
      ex_wr     = r_wr;
      // An invalid ID instruction may still carry stale we/ctrl; gate them.
      ex_we     = r_we && r_valid;
      ex_ctrl   = r_valid ? r_ctrl : CTRL_NOP;
      ex_op_a   = fwd_a_sel ? fwd_data_a : r_rd1;
      ex_op_b   = fwd_b_sel ? fwd_data_b : r_rd2;
      stall_req = w_stall_req;
   end

endmodule

// File: tb/tb_id_ex_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe
// Directed scoreboard bench for id_ex_pipe. Each stimulus sample pushes the
// hand-computed outputs expected at that sample; a monitor pops and compares.
// Counters are 8 bits here so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe;
   import id_ex_pipe_pkg::*;

   localparam int unsigned XLEN = 32;
   localparam int unsigned CW   = 8;

   localparam logic [11:0] C_ADDI = 12'h080;  // alub_sel=1
   localparam logic [11:0] C_LW   = 12'h0A8;  // alub_sel=1, wd_sel=01, mem_re=1
   localparam logic [11:0] C_ADD  = 12'h000;

   logic              clk;
   logic              rst_n;
   logic              id_valid;
   logic [XLEN-1:0]   id_pc;
   logic [4:0]        id_rs1, id_rs2;
   logic [XLEN-1:0]   id_rD1, id_rD2, id_imm;
   logic [4:0]        id_wr;
   logic              id_we;
   logic [CTRL_W-1:0] id_ctrl;
   logic              id_use_rs1, id_use_rs2;
   logic              stall_in, flush;
   logic              fwd_a_sel, fwd_b_sel;
   logic [XLEN-1:0]   fwd_data_a, fwd_data_b;
   logic              ex_valid;
   logic [XLEN-1:0]   ex_pc, ex_imm;
   logic [4:0]        ex_rs1, ex_rs2, ex_wr;
   logic              ex_we;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [XLEN-1:0]   ex_op_a, ex_op_b;
   logic              stall_req;
   logic [CW-1:0]     stall_cnt, flush_cnt;

   id_ex_pipe #(.XLEN(XLEN), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_pc      (id_pc),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_rD1     (id_rD1),
      .id_rD2     (id_rD2),
      .id_imm     (id_imm),
      .id_wr      (id_wr),
      .id_we      (id_we),
      .id_ctrl    (id_ctrl),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .stall_in   (stall_in),
      .flush      (flush),
      .fwd_a_sel  (fwd_a_sel),
      .fwd_b_sel  (fwd_b_sel),
      .fwd_data_a (fwd_data_a),
      .fwd_data_b (fwd_data_b),
      .ex_valid   (ex_valid),
      .ex_pc      (ex_pc),
      .ex_imm     (ex_imm),
      .ex_rs1     (ex_rs1),
      .ex_rs2     (ex_rs2),
      .ex_wr      (ex_wr),
      .ex_we      (ex_we),
      .ex_ctrl    (ex_ctrl),
      .ex_op_a    (ex_op_a),
      .ex_op_b    (ex_op_b),
      .stall_req  (stall_req),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        chk_data;
      logic        chk_ops;
      logic [31:0] valid, pc, wr, we, ctrl, imm, sreq, scnt, fcnt, opa, opb;
   } exp_t;

   exp_t sb_q[$];
   exp_t m_e;
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, expv);
      end
   endtask

   // Monitor: outputs are settled 3 time units after the stimulus edge.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            check("ex_valid",  32'(ex_valid),  m_e.valid);
            check("ex_we",     32'(ex_we),     m_e.we);
            check("ex_ctrl",   32'(ex_ctrl),   m_e.ctrl);
            check("stall_req", 32'(stall_req), m_e.sreq);
            check("stall_cnt", 32'(stall_cnt), m_e.scnt);
            check("flush_cnt", 32'(flush_cnt), m_e.fcnt);
            if (m_e.chk_data) begin
               check("ex_pc",  ex_pc,         m_e.pc);
               check("ex_wr",  32'(ex_wr),    m_e.wr);
               check("ex_imm", ex_imm,        m_e.imm);
            end
            if (m_e.chk_ops) begin
               check("ex_op_a", ex_op_a, m_e.opa);
               check("ex_op_b", ex_op_b, m_e.opb);
            end
         end
      end
   end

   task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] imm, input logic [4:0] wr, input logic we,
                           input logic [11:0] ctrl, input logic u1, input logic u2);
      id_valid = v;   id_pc = pc;     id_rs1 = rs1;  id_rs2 = rs2;
      id_rD1 = rd1;   id_rD2 = rd2;   id_imm = imm;  id_wr = wr;
      id_we = we;     id_ctrl = ctrl; id_use_rs1 = u1; id_use_rs2 = u2;
   endtask

   task automatic expect_out(input logic cd, input logic [31:0] v, input logic [31:0] pc,
                             input logic [31:0] wr, input logic [31:0] we, input logic [31:0] ctrl,
                             input logic [31:0] imm, input logic [31:0] sreq, input logic [31:0] scnt,
                             input logic [31:0] fcnt, input logic co, input logic [31:0] opa,
                             input logic [31:0] opb);
      exp_t e;
      e.chk_data = cd; e.chk_ops = co;
      e.valid = v; e.pc = pc; e.wr = wr; e.we = we; e.ctrl = ctrl; e.imm = imm;
      e.sreq = sreq; e.scnt = scnt; e.fcnt = fcnt; e.opa = opa; e.opb = opb;
      sb_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; stall_in = 1'b0; flush = 1'b0;
      fwd_a_sel = 1'b0; fwd_b_sel = 1'b0; fwd_data_a = '0; fwd_data_b = '0;
      drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0);
      repeat (2) @(posedge clk);

      // Reset state; present addi x5,x0,7
      @(negedge clk); rst_n = 1'b1;
      drive_id(1, 'h100, 0, 0, 0, 0, 7, 5, 1, C_ADDI, 1, 0);
      expect_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

      // addi in EX; present lw x6,4(x5)
      @(negedge clk);
      drive_id(1, 'h104, 5, 0, 'h200, 0, 4, 6, 1, C_LW, 1, 0);
      expect_out(1, 1, 'h100, 5, 1, C_ADDI, 7, 0, 0, 0, 1, 0, 0);

      // lw in EX; add x7,x6,x1 -> load-use
      @(negedge clk);
      drive_id(1, 'h108, 6, 1, 'h55, 'h10, 0, 7, 1, C_ADD, 1, 1);
      expect_out(1, 1, 'h104, 6, 1, C_LW, 4, 1, 0, 0, 1, 'h200, 0);

      // bubble; add re-presented
      @(negedge clk);
      drive_id(1, 'h108, 6, 1, 'h300, 'h10, 0, 7, 1, C_ADD, 1, 1);
      expect_out(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

      // add captured; present lw x0,0(x1)
      @(negedge clk);
      drive_id(1, 'h10C, 1, 0, 'h10, 0, 0, 0, 1, C_LW, 1, 0);
      expect_out(1, 1, 'h108, 7, 1, C_ADD, 0, 0, 1, 0, 1, 'h300, 'h10);

      // lw x0 in EX; ID reads x0 -> no stall
      @(negedge clk);
      drive_id(1, 'h110, 0, 0, 0, 0, 0, 8, 1, C_ADD, 1, 1);
      expect_out(1, 1, 'h10C, 0, 1, C_LW, 0, 0, 1, 0, 1, 'h10, 0);

      // no bubble: add x8 captured; present lw x9,0(x2)
      @(negedge clk);
      drive_id(1, 'h114, 2, 0, 'h400, 0, 0, 9, 1, C_LW, 1, 0);
      expect_out(1, 1, 'h110, 8, 1, C_ADD, 0, 0, 1, 0, 1, 0, 0);

      // load-use together with flush -> flush wins
      @(negedge clk); flush = 1'b1;
      drive_id(1, 'h118, 9, 3, 0, 0, 0, 10, 1, C_ADD, 1, 1);
      expect_out(1, 1, 'h114, 9, 1, C_LW, 0, 0, 1, 0, 1, 'h400, 0);

      @(negedge clk); flush = 1'b0;
      drive_id(1, 'h200, 0, 0, 0, 0, 5, 11, 1, C_ADDI, 1, 0);
      expect_out(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);

      // stall_in for three edges with changing ID
      @(negedge clk); stall_in = 1'b1;
      drive_id(1, 'h204, 0, 0, 0, 0, 9, 12, 1, C_ADDI, 1, 0);
      expect_out(1, 1, 'h200, 11, 1, C_ADDI, 5, 0, 1, 1, 1, 0, 0);
      @(negedge clk);
      drive_id(1, 'h208, 0, 0, 0, 0, 'hA, 13, 1, C_ADDI, 1, 0);
      expect_out(1, 1, 'h200, 11, 1, C_ADDI, 5, 0, 1, 1, 1, 0, 0);
      @(negedge clk);
      drive_id(1, 'h20C, 0, 0, 0, 0, 'hB, 14, 1, C_LW, 1, 0);
      expect_out(1, 1, 'h200, 11, 1, C_ADDI, 5, 0, 1, 1, 1, 0, 0);
      @(negedge clk); stall_in = 1'b0;
      drive_id(1, 'h210, 0, 0, 0, 0, 'hC, 15, 1, C_ADDI, 1, 0);
      expect_out(1, 1, 'h200, 11, 1, C_ADDI, 5, 0, 1, 1, 1, 0, 0);

      // capture resumes
      @(negedge clk);
      drive_id(1, 'h214, 1, 2, 'h11, 'h22, 0, 16, 1, C_ADD, 1, 1);
      expect_out(1, 1, 'h210, 15, 1, C_ADDI, 'hC, 0, 1, 1, 1, 0, 0);

      // forwarding on A only
      @(negedge clk);
      fwd_a_sel = 1'b1; fwd_data_a = 'hDEADBEEF; fwd_b_sel = 1'b0; fwd_data_b = 'hCAFE0000;
      drive_id(1, 'h218, 3, 4, 'h33, 'h44, 0, 17, 1, C_ADD, 1, 1);
      expect_out(1, 1, 'h214, 16, 1, C_ADD, 0, 0, 1, 1, 1, 'hDEADBEEF, 'h22);

      // forwarding on B only
      @(negedge clk);
      fwd_a_sel = 1'b0; fwd_data_a = 'h0BAD0BAD; fwd_b_sel = 1'b1; fwd_data_b = 'h12345678;
      drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0);
      expect_out(1, 1, 'h218, 17, 1, C_ADD, 0, 0, 1, 1, 1, 'h33, 'h12345678);

      // 2^CW+3 further stalls; counter must stick at all-ones
      for (int i = 0; i <= 258; i++) begin
         @(negedge clk);
         fwd_b_sel = 1'b0;
         drive_id(1, 'h300, 1, 0, 0, 0, 0, 6, 1, C_LW, 1, 0);
         if (i == 253) expect_out(0, 0, 0, 0, 0, 0, 0, 0, 254, 1, 0, 0, 0);
         if (i == 254) expect_out(0, 0, 0, 0, 0, 0, 0, 0, 255, 1, 0, 0, 0);
         @(negedge clk);
         drive_id(1, 'h304, 6, 0, 0, 0, 0, 7, 1, C_ADD, 1, 0);
         if (i == 0) expect_out(1, 1, 'h300, 6, 1, C_LW, 0, 1, 1, 1, 0, 0, 0);
      end

      @(negedge clk);
      drive_id(1, 'h300, 1, 0, 0, 0, 0, 6, 1, C_LW, 1, 0);
      expect_out(0, 0, 0, 0, 0, 0, 0, 0, 255, 1, 0, 0, 0);

      // reset asserted while a load-use stall is requested
      @(negedge clk); rst_n = 1'b0;
      drive_id(1, 'h304, 6, 0, 0, 0, 0, 7, 1, C_ADD, 1, 0);
      expect_out(1, 1, 'h300, 6, 1, C_LW, 0, 1, 255, 1, 0, 0, 0);

      @(negedge clk); rst_n = 1'b1;
      expect_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

      @(negedge clk);
      drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0);
      expect_out(1, 1, 'h304, 7, 1, C_ADD, 0, 0, 0, 0, 0, 0, 0);

      for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
      @(negedge clk);
      #5;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Pipeline register between the ID and EX stages of the 5-stage RV32I core.
- Captures decoded operands and control from ID, and detects load-use hazards so it can request a one-cycle stall and insert a bubble.
- Applies the registered forwarding selects in EX to produce the final ALU operands.
- Keeps saturating stall/flush event counters for the trace test harness.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of each event counter; saturates at all-ones.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1, id_rs2  in  5  source register indices.
- id_rD1, id_rD2  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_wr  in  5  destination register.
- id_we  in  1  register write enable.
- id_ctrl  in  12  packed control {alu_op[3:0], alub_sel, wd_sel[1:0], mem_we, mem_re, br_type[2:0]}.
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1 / rs2.
- stall_in  in  1  downstream freeze; hold all state.
- flush  in  1  branch/jump resolved taken in EX; kill the ID instruction.
- fwd_a_sel, fwd_b_sel  in  1  forwarding selects, valid during the EX cycle.
- fwd_data_a, fwd_data_b  in  XLEN  forwarded values for A / B.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_imm  out  XLEN  registered pc / immediate.
- ex_rs1, ex_rs2, ex_wr  out  5  registered indices.
- ex_we  out  1  registered write enable, gated by ex_valid.
- ex_ctrl  out  12  registered control; all zero when not valid.
- ex_op_a, ex_op_b  out  XLEN  resolved operands.
- stall_req  out  1  load-use stall request to the PC and IF/ID stages.
- stall_cnt, flush_cnt  out  CNT_W  event counters.

Behaviour:
- Reset (rst_n low at a clock edge) clears every register:
  - ex_valid=0, ex_we=0, ex_ctrl=0, all data and index registers 0, both counters 0.
  - ex_op_a and ex_op_b therefore read 0 unless a forward select is high.
- Load-use detection (combinational):
  - stall_req = ex_valid & ex_ctrl.mem_re & (ex_wr!=0) & id_valid & ((id_use_rs1 & id_rs1==ex_wr) | (id_use_rs2 & id_rs2==ex_wr)).
  - stall_req is forced to 0 when flush=1.
- Per-edge update priority, highest first:
  1. Reset.
  2. stall_in: all registers hold, counters hold.
  3. flush: load a bubble (ex_valid=0, ex_we=0, ex_ctrl=0); flush_cnt++.
  4. stall_req: load a bubble; stall_cnt++. The ID instruction is re-presented next cycle because upstream freezes on stall_req.
  5. Normal: capture all id_* fields; ex_valid=id_valid.
- Bubble contents: ex_pc, ex_imm, indices and data may be don't-care, but ex_we and ex_ctrl must be 0.
- Latency: one cycle from ID capture to EX outputs.
- At most one stall per load: the bubble clears ex_valid, so stall_req drops the following cycle.
- Operand resolution (combinational in EX):
  - ex_op_a = fwd_a_sel ? fwd_data_a : rD1_q.
  - ex_op_b = fwd_b_sel ? fwd_data_b : rD2_q.
  - A and B are independent; the block applies no priority between them.
  - ex_op_b carries the rs2 value; immediate selection is done in the ALU stage via alub_sel.
- Counters increment by 1 and saturate at 2^CNT_W-1, never wrapping.
- Simultaneous flush and load-use: flush wins, flush_cnt increments, stall_cnt is unchanged.
- Reset asserted mid-stall: next cycle shows ex_valid=0, stall_req=0.
- x0: a load with ex_wr=0 never stalls.

Decomposition:
- Shared package define.v holds:
  - control bit-field offsets (CTRL_ALUOP, CTRL_MEMRE, ...);
  - the CTRL_W=12 constant;
  - the NOP/bubble control constant (all zero).
- One natural sub-module, sat_counter (CNT_W parameter, inc, hold); instantiate it twice.

Test Plan:
- Reset then release; ID presents addi x5,x0,7 (pc=0x100, imm=7, wr=5, we=1) -> next cycle ex_valid=1, ex_pc=0x100, ex_wr=5, ex_we=1, ex_imm=7.
- lw x6 in EX; ID presents add x7,x6,x1 (use_rs1=1, rs1=6) -> stall_req=1, next cycle ex_valid=0 and ex_ctrl=0, stall_cnt=1, stall_req=0, add captured one cycle later.
- lw x0 in EX; ID reads x0 -> stall_req=0, no bubble.
- flush=1 while stall_req would be 1 -> bubble inserted, flush_cnt=1, stall_cnt=0.
- stall_in=1 for 3 cycles with changing id_* -> all ex_* outputs and counters unchanged; capture resumes the cycle after release.
- rD1_q=0x11, fwd_a_sel=1, fwd_data_a=0xDEADBEEF, fwd_b_sel=0, rD2_q=0x22 -> ex_op_a=0xDEADBEEF, ex_op_b=0x22. Then force 2^CNT_W+3 stalls -> stall_cnt stays at 0xFFFF.
